// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage arithmetic units: operation codes and
// the state encoding of the iterative add/subtract controller.
package alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit ripple slice of the iterative adder. Besides the slice sum
// and carry out it exposes the carry into the slice MSB, which the top level
// needs on the final slice to form the signed overflow flag.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full_s;

  // Slice addition; the MSB carry-in is recovered from the MSB sum bit
  always_comb begin
    full_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    s      = full_s[CHUNK-1:0];
    cout   = full_s[CHUNK];
    c_msb  = full_s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
  end

endmodule

// File: rtl/addsub_iter.sv
// Multi-cycle add/subtract/compare unit. Operands are latched on an accepted
// start, then the carry chain is resolved CHUNK bits per clock by shifting
// the operand registers right and shifting slice sums in from the top. The
// final slice drives result and flags, which then hold until the next
// operation completes.
module addsub_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_e                   state_r, state_nx_s;
  logic [WIDTH-1:0]         a_r, b_r, sum_r;
  logic [1:0]               op_r;
  logic                     carry_r;
  logic [IDXW-1:0]          idx_r;
  logic                     busy_r, done_r, cout_r, ovf_r, zero_r, neg_r;
  logic [WIDTH-1:0]         result_r;

  logic                     accept_s, last_s;
  logic [CHUNK-1:0]         slice_s;
  logic                     slice_cout_s, slice_cmsb_s;
  logic [WIDTH+CHUNK-1:0]   cat_s;
  logic [WIDTH-1:0]         sum_full_s, res_s;
  logic                     ovf_s, zero_s, neg_s;

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_r[CHUNK-1:0]),
    .y     (b_r[CHUNK-1:0]),
    .cin   (carry_r),
    .s     (slice_s),
    .cout  (slice_cout_s),
    .c_msb (slice_cmsb_s)
  );

  // State register; reset wins over any start on the same edge
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state logic plus start-acceptance and last-slice decode
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nx_s = ST_DONE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Sum after this slice and the result/flags it implies on the last slice
  always_comb begin
    cat_s      = {slice_s, sum_r};
    sum_full_s = cat_s[WIDTH+CHUNK-1:CHUNK];
    ovf_s      = slice_cmsb_s ^ slice_cout_s;
    zero_s     = (sum_full_s == {WIDTH{1'b0}});
    neg_s      = sum_full_s[WIDTH-1];
    case (op_r)
      OP_ADD:  res_s = sum_full_s;
      OP_SUB:  res_s = sum_full_s;
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, neg_s ^ ovf_s};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, ~slice_cout_s};
      default: res_s = sum_full_s;
    endcase
  end

  // Operand capture, per-slice iteration and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      op_r     <= OP_ADD;
      carry_r  <= 1'b0;
      idx_r    <= {IDXW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_RUN);
      done_r <= (state_nx_s == ST_DONE);
      if (accept_s) begin
        a_r     <= a;
        b_r     <= (op == OP_ADD) ? b : ~b;
        op_r    <= op;
        carry_r <= (op != OP_ADD);
        idx_r   <= {IDXW{1'b0}};
      end else if (state_r == ST_RUN) begin
        a_r     <= a_r >> CHUNK;
        b_r     <= b_r >> CHUNK;
        sum_r   <= sum_full_s;
        carry_r <= slice_cout_s;
        idx_r   <= idx_r + IDXW'(1);
        if (last_s) begin
          result_r <= res_s;
          cout_r   <= slice_cout_s;
          ovf_r    <= ovf_s;
          zero_r   <= zero_s;
          neg_r    <= neg_s;
        end
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;
  assign neg    = neg_r;

endmodule

// File: tb/tb_addsub_iter.sv
// Scoreboard bench for addsub_iter: three instances (32/8, 16/16, 12/4)
// driven one operation at a time; a monitor checks every cycle's busy,
// done timing, results and held outputs against a plain-arithmetic model.
module tb_addsub_iter;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        co, ov, ze, ne;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic [2:0]  rst_v   = 3'b111;
  logic [2:0]  start_v = 3'b000;
  logic [1:0]  op_v [3];
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  busy_w, done_w, cout_w, ovf_w, zero_w, neg_w;
  logic [31:0] res0;
  logic [15:0] res1;
  logic [11:0] res2;

  exp_t q0[$], q1[$], q2[$];
  exp_t last_exp [3];
  int   bf [3];
  int   bt [3];
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_iter #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .op(op_v[0]),
    .a(a_v[0]), .b(b_v[0]), .busy(busy_w[0]), .done(done_w[0]),
    .result(res0), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]), .neg(neg_w[0]));

  addsub_iter #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .op(op_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .busy(busy_w[1]), .done(done_w[1]),
    .result(res1), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]), .neg(neg_w[1]));

  addsub_iter #(.WIDTH(12), .CHUNK(4)) u2 (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .op(op_v[2]),
    .a(a_v[2][11:0]), .b(b_v[2][11:0]), .busy(busy_w[2]), .done(done_w[2]),
    .result(res2), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]), .neg(neg_w[2]));

  function automatic int wid(input int d);
    case (d)
      0:       return 32;
      1:       return 16;
      default: return 12;
    endcase
  endfunction

  function automatic int nch(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic exp_t zexp();
    exp_t e;
    e.res = 32'd0; e.co = 1'b0; e.ov = 1'b0; e.ze = 1'b0; e.ne = 1'b0; e.due = 0;
    return e;
  endfunction

  // Reference: plain integer arithmetic on w-bit values
  function automatic exp_t model(input int w, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned mask, av, bv, full, sum;
    longint sa_v, sb_v;
    bit sa, sb, ss;
    mask = (64'd1 << w) - 64'd1;
    av = 64'(a) & mask;
    bv = 64'(b) & mask;
    if (op == OP_ADD) full = av + bv;
    else              full = av + (~bv & mask) + 64'd1;
    sum = full & mask;
    sa = ((av >> (w - 1)) & 64'd1) != 64'd0;
    sb = ((bv >> (w - 1)) & 64'd1) != 64'd0;
    ss = ((sum >> (w - 1)) & 64'd1) != 64'd0;
    sa_v = sa ? longint'(av) - longint'(64'd1 << w) : longint'(av);
    sb_v = sb ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
    case (op)
      OP_SLT:  e.res = (sa_v < sb_v) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (av < bv) ? 32'd1 : 32'd0;
      default: e.res = 32'(sum);
    endcase
    e.co = ((full >> w) & 64'd1) != 64'd0;
    if (op == OP_ADD) e.ov = (sa == sb) && (ss != sa);
    else              e.ov = (sa != sb) && (ss != sa);
    e.ze = (sum == 64'd0);
    e.ne = ss;
    e.due = 0;
    return e;
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qdue(input int d);
    case (d)
      0:       return q0[0].due;
      1:       return q1[0].due;
      default: return q2[0].due;
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qclear(input int d);
    case (d)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Per-cycle check of one instance against the scoreboard
  task automatic mon(input int d, input logic dn, input logic bs, input logic [31:0] res,
                     input logic co, input logic ov, input logic ze, input logic ne);
    exp_t h;
    logic eb;
    eb = (cyc >= bf[d]) && (cyc <= bt[d]);
    chk($sformatf("d%0d busy cyc%0d", d, cyc), 64'(bs), 64'(eb));
    if (dn) begin
      if (qsize(d) == 0) begin
        flag_fail($sformatf("d%0d unexpected done cyc%0d", d, cyc));
      end else begin
        h = qpop(d);
        chk($sformatf("d%0d done_cycle", d), 64'(cyc), 64'(h.due));
        chk($sformatf("d%0d result", d), 64'(res), 64'(h.res));
        chk($sformatf("d%0d flags{c,v,z,n}", d), 64'({co, ov, ze, ne}),
            64'({h.co, h.ov, h.ze, h.ne}));
        last_exp[d] = h;
      end
    end else begin
      if (qsize(d) != 0 && cyc > qdue(d)) begin
        h = qpop(d);
        flag_fail($sformatf("d%0d missing done due cyc%0d", d, h.due));
      end
      chk($sformatf("d%0d held outputs cyc%0d", d, cyc), {28'd0, res, co, ov, ze, ne},
          {28'd0, last_exp[d].res, last_exp[d].co, last_exp[d].ov, last_exp[d].ze, last_exp[d].ne});
    end
  endtask

  // Monitor: sample all instances away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, done_w[0], busy_w[0], res0,        cout_w[0], ovf_w[0], zero_w[0], neg_w[0]);
      mon(1, done_w[1], busy_w[1], 32'(res1),   cout_w[1], ovf_w[1], zero_w[1], neg_w[1]);
      mon(2, done_w[2], busy_w[2], 32'(res2),   cout_w[2], ovf_w[2], zero_w[2], neg_w[2]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation and run to its done cycle, optionally pulsing
  // start with unrelated operands while the unit is busy
  task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit junk);
    exp_t e;
    e = model(wid(d), op, a, b);
    e.due = cyc + nch(d) + 1;
    qpush(d, e);
    bf[d] = cyc + 1;
    bt[d] = cyc + nch(d);
    op_v[d] = op; a_v[d] = a; b_v[d] = b; start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    for (int i = 0; i < nch(d); i++) begin
      if (junk) begin
        start_v[d] = 1'b1;
        op_v[d] = 2'($urandom);
        a_v[d] = $urandom;
        b_v[d] = $urandom;
      end
      tick();
      start_v[d] = 1'b0;
    end
  endtask

  // Start an operation and reset it two cycles in
  task automatic rst_mid(input int d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bf[d] = cyc + 1;
    bt[d] = cyc + nch(d);
    op_v[d] = op; a_v[d] = a; b_v[d] = b; start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    tick();
    rst_v[d] = 1'b1;
    tick();
    rst_v[d] = 1'b0;
    bt[d] = cyc - 1;
    last_exp[d] = zexp();
    qclear(d);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      op_v[d] = 2'b00; a_v[d] = 32'd0; b_v[d] = 32'd0;
      bf[d] = 1; bt[d] = 0;
      last_exp[d] = zexp();
    end
    tick();
    tick();
    mon_en = 1'b1;
    rst_v = 3'b000;
    tick();

    issue(0, OP_SUB,  32'd5,          32'd3,          1'b0);
    issue(0, OP_ADD,  32'h7FFF_FFFF,  32'h0000_0001,  1'b0);
    issue(0, OP_SLT,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0);
    issue(0, OP_SLTU, 32'hFFFF_FFFF,  32'h0000_0001,  1'b0);
    issue(0, OP_SUB,  32'h0000_1234,  32'h0000_1234,  1'b1);
    issue(0, OP_ADD,  32'h0000_0001,  32'h0000_0002,  1'b0);
    tick();
    tick();
    issue(0, OP_ADD,  32'h1111_1111,  32'h2222_2222,  1'b0);
    rst_mid(0, OP_SUB, 32'hDEAD_BEEF, 32'h0000_0042);
    tick();
    tick();
    tick();
    issue(1, OP_ADD,  32'h0000_FFFF,  32'h0000_0001,  1'b0);
    issue(1, OP_SUB,  32'h0000_8000,  32'h0000_0001,  1'b0);
    issue(2, OP_SUB,  32'h0000_0000,  32'h0000_0001,  1'b0);
    issue(2, OP_SLT,  32'h0000_0800,  32'h0000_07FF,  1'b0);

    for (int k = 0; k < 60; k++) begin
      int d;
      logic [31:0] ra, rb;
      d  = ($urandom_range(0, 9) < 6) ? 0 : ((k % 2 == 1) ? 1 : 2);
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? ra : pick();
      issue(d, 2'($urandom), ra, rb, $urandom_range(0, 3) == 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    for (int i = 0; i < 8; i++) tick();
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d pending at end", d), 64'(qsize(d)), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
